// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch
// ----------------------------------------------------------------------------
// Instruction fetch stage. Holds the program counter, issues one instruction
// memory request at a time, buffers the returned word and offers it to decode
// over the give/get handshake. A redirect from execute replaces the PC. Any
// buffered word is dropped, and a response that is still in flight is
// swallowed.
//
// Ports:
//   clk              core clock
//   resetn_i         asynchronous active-low reset
//   IF_MEM_req_o     fetch request, held until MEM_IF_valid_i
//   IF_MEM_addr_o    fetch address (word aligned), stable while requesting
//   MEM_IF_valid_i   memory response valid, completes the request
//   MEM_IF_data_i    instruction word returned by memory
//   IF_ID_give_o     instruction available for decode
//   ID_IF_get_i      decode ready to accept
//   IF_ID_instr_o    buffered instruction
//   IF_ID_pc_o       PC of the buffered instruction
//   EX_IF_branch_i   redirect pulse from execute
//   EX_IF_target_i   redirect target (low two bits ignored)
//
// State table:
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   S_IDLE    | one cycle after reset, no request
//   S_REQ     | request to r_pc outstanding
//   S_DISCARD | abandoned request outstanding, its response will be dropped
//   S_GIVE    | buffered instruction offered to decode
// ============================================================================
module instr_fetch #(
    parameter int unsigned        BITSIZE    = 32,
    parameter logic [BITSIZE-1:0] RESET_ADDR = '0
) (
    input  logic               clk,
    input  logic               resetn_i,
    output logic               IF_MEM_req_o,
    output logic [BITSIZE-1:0] IF_MEM_addr_o,
    input  logic               MEM_IF_valid_i,
    input  logic [31:0]        MEM_IF_data_i,
    output logic               IF_ID_give_o,
    input  logic               ID_IF_get_i,
    output logic [31:0]        IF_ID_instr_o,
    output logic [BITSIZE-1:0] IF_ID_pc_o,
    input  logic               EX_IF_branch_i,
    input  logic [BITSIZE-1:0] EX_IF_target_i
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2,
        S_GIVE    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BITSIZE-1:0] r_pc;
    logic [BITSIZE-1:0] r_disc_addr;
    logic [31:0]        r_instr_buf;
    logic [BITSIZE-1:0] r_pc_buf;

    logic [BITSIZE-1:0] w_target;
    logic [BITSIZE-1:0] w_pc_inc;
    logic               w_accept;
    logic               w_abandon;

    // Masking (rather than slicing) keeps every target bit in use.
    assign w_target  = EX_IF_target_i & {{(BITSIZE-2){1'b1}}, 2'b00};
    assign w_pc_inc  = r_pc + {{(BITSIZE-3){1'b0}}, 3'b100};
    assign w_accept  = (r_state == S_REQ) && MEM_IF_valid_i && !EX_IF_branch_i;
    assign w_abandon = (r_state == S_REQ) && !MEM_IF_valid_i && EX_IF_branch_i;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (MEM_IF_valid_i && !EX_IF_branch_i) begin
                    w_state_nxt = S_GIVE;
                end else if (!MEM_IF_valid_i && EX_IF_branch_i) begin
                    w_state_nxt = S_DISCARD;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_DISCARD: begin
                if (MEM_IF_valid_i) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_GIVE: begin
                if (EX_IF_branch_i || ID_IF_get_i) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        IF_MEM_req_o  = 1'b0;
        IF_MEM_addr_o = r_pc;
        IF_ID_give_o  = 1'b0;
        case (r_state)
            S_REQ: begin
                IF_MEM_req_o = 1'b1;
            end
            S_DISCARD: begin
                // r_pc may already hold the redirect target; memory must
                // still see the address of the request it is serving.
                IF_MEM_req_o  = 1'b1;
                IF_MEM_addr_o = r_disc_addr;
            end
            S_GIVE: begin
                // A redirect in the same cycle kills the offer immediately.
                IF_ID_give_o = !EX_IF_branch_i;
            end
            default: begin
                IF_MEM_req_o = 1'b0;
            end
        endcase
    end

    assign IF_ID_instr_o = r_instr_buf;
    assign IF_ID_pc_o    = r_pc_buf;

    // ------------------------------------------------------------------
    // PC and buffers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            r_pc        <= RESET_ADDR;
            r_disc_addr <= RESET_ADDR;
            r_instr_buf <= '0;
            r_pc_buf    <= '0;
        end else begin
            if (EX_IF_branch_i) begin
                r_pc <= w_target;
            end else if (w_accept) begin
                r_pc <= w_pc_inc;
            end

            if (w_accept) begin
                r_instr_buf <= MEM_IF_data_i;
                r_pc_buf    <= r_pc;
            end

            if (w_abandon) begin
                r_disc_addr <= r_pc;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        get;
        logic        br;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_give;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] data;
    logic        give;
    logic        get;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        br;
    logic [31:0] tgt;

    int checks;
    int errors;
    int step_no;
    vec_t vq[$];

    instr_fetch #(
        .BITSIZE    (32),
        .RESET_ADDR (32'h0)
    ) dut (
        .clk            (clk),
        .resetn_i       (resetn),
        .IF_MEM_req_o   (req),
        .IF_MEM_addr_o  (addr),
        .MEM_IF_valid_i (valid),
        .MEM_IF_data_i  (data),
        .IF_ID_give_o   (give),
        .ID_IF_get_i    (get),
        .IF_ID_instr_o  (instr),
        .IF_ID_pc_o     (pc),
        .EX_IF_branch_i (br),
        .EX_IF_target_i (tgt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic v, input logic [31:0] d, input logic g, input logic b,
        input logic [31:0] t, input logic er, input logic [31:0] ea,
        input logic eg, input logic [31:0] ei, input logic [31:0] ep);
        vec_t r;
        r.valid = v; r.data = d; r.get = g; r.br = b; r.tgt = t;
        r.e_req = er; r.e_addr = ea; r.e_give = eg; r.e_instr = ei; r.e_pc = ep;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, step_no, act, exp);
        end
    endtask

    // Called at a falling edge: drive, settle, compare, advance one cycle.
    task automatic step(input vec_t v);
        valid = v.valid; data = v.data; get = v.get; br = v.br; tgt = v.tgt;
        #1;
        chk("req", 32'(req), 32'(v.e_req));
        if (v.e_req) chk("addr", addr, v.e_addr);
        chk("give", 32'(give), 32'(v.e_give));
        chk("instr", instr, v.e_instr);
        chk("pc", pc, v.e_pc);
        step_no++;
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0; step_no = 0;
        resetn = 1'b0; valid = 1'b0; data = '0; get = 1'b0; br = 1'b0; tgt = '0;

        //          valid data          get br tgt           req addr          give instr         pc
        // zero-wait streaming 0x0, 0x4, 0x8, 0xC
        vq.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0));
        vq.push_back(mk(1, 32'h11110000, 1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0));
        vq.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h11110000, 32'h0));
        vq.push_back(mk(1, 32'h11110004, 1, 0, 32'h0,        1, 32'h4,        0, 32'h11110000, 32'h0));
        vq.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h11110004, 32'h4));
        vq.push_back(mk(1, 32'h11110008, 1, 0, 32'h0,        1, 32'h8,        0, 32'h11110004, 32'h4));
        vq.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h11110008, 32'h8));
        vq.push_back(mk(1, 32'h1111000C, 1, 0, 32'h0,        1, 32'hC,        0, 32'h11110008, 32'h8));
        // decode stalls for 5 cycles, then accepts
        for (int i = 0; i < 5; i++)
            vq.push_back(mk(0, 32'h0,    0, 0, 32'h0,        0, 32'h0,        1, 32'h1111000C, 32'hC));
        vq.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h1111000C, 32'hC));
        // memory response delayed 3 cycles
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(0, 32'h0,    1, 0, 32'h0,        1, 32'h10,       0, 32'h1111000C, 32'hC));
        vq.push_back(mk(1, 32'h11110010, 1, 0, 32'h0,        1, 32'h10,       0, 32'h1111000C, 32'hC));
        vq.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h11110010, 32'h10));
        // branch to 0x103 while 0x14 pending -> discard, refetch at 0x100
        vq.push_back(mk(0, 32'h0,        1, 1, 32'h103,      1, 32'h14,       0, 32'h11110010, 32'h10));
        vq.push_back(mk(1, 32'hDEAD0014, 1, 0, 32'h0,        1, 32'h14,       0, 32'h11110010, 32'h10));
        vq.push_back(mk(1, 32'h11110100, 1, 0, 32'h0,        1, 32'h100,      0, 32'h11110010, 32'h10));
        vq.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h11110100, 32'h100));
        vq.push_back(mk(1, 32'h11110104, 1, 0, 32'h0,        1, 32'h104,      0, 32'h11110100, 32'h100));
        // branch in GIVE with get=1: no transfer, next request 0x40
        vq.push_back(mk(0, 32'h0,        1, 1, 32'h40,       0, 32'h0,        0, 32'h11110104, 32'h104));
        // branch to 0xFFFFFFFE while 0x40 pending; response after two cycles
        vq.push_back(mk(0, 32'h0,        1, 1, 32'hFFFFFFFE, 1, 32'h40,       0, 32'h11110104, 32'h104));
        vq.push_back(mk(0, 32'h0,        1, 0, 32'h0,        1, 32'h40,       0, 32'h11110104, 32'h104));
        vq.push_back(mk(1, 32'hDEAD0040, 1, 0, 32'h0,        1, 32'h40,       0, 32'h11110104, 32'h104));
        vq.push_back(mk(1, 32'h1111FFFC, 1, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h11110104, 32'h104));
        vq.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h1111FFFC, 32'hFFFFFFFC));
        // PC wrapped to 0; valid and branch together drop the word, stay requesting
        vq.push_back(mk(1, 32'hDEAD0000, 1, 1, 32'h200,      1, 32'h0,        0, 32'h1111FFFC, 32'hFFFFFFFC));
        vq.push_back(mk(1, 32'h22220200, 1, 0, 32'h0,        1, 32'h200,      0, 32'h1111FFFC, 32'hFFFFFFFC));
        vq.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h22220200, 32'h200));

        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_give", 32'(give), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);

        @(negedge clk);
        resetn = 1'b1;
        foreach (vq[i]) step(vq[i]);

        // Reset asserted in the middle of a request to 0x204.
        valid = 1'b0; get = 1'b1; br = 1'b0; tgt = '0;
        #1;
        chk("mid_req", 32'(req), 32'h1);
        chk("mid_addr", addr, 32'h204);
        #1;
        resetn = 1'b0;
        #1;
        chk("async_req", 32'(req), 32'h0);
        chk("async_addr", addr, 32'h0);
        chk("async_give", 32'(give), 32'h0);
        chk("async_instr", instr, 32'h0);
        chk("async_pc", pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        // branch during IDLE redirects the very first request
        step(mk(0, 32'h0,        1, 1, 32'h83, 0, 32'h0,  0, 32'h0,        32'h0));
        step(mk(1, 32'h33330080, 1, 0, 32'h0,  1, 32'h80, 0, 32'h0,        32'h0));
        step(mk(0, 32'h0,        1, 0, 32'h0,  0, 32'h0,  1, 32'h33330080, 32'h80));
        step(mk(0, 32'h0,        1, 0, 32'h0,  1, 32'h84, 0, 32'h33330080, 32'h80));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the in-order core pipeline. Maintains the program counter, fetches one 32-bit instruction at a time from instruction memory and hands it to instruction decode over the IF→ID give/get handshake. Redirects the PC on a taken branch/jump reported by execute, discarding any in-flight or buffered instruction.

## Interface
Parameters:
- BITSIZE, 32, width of PC and addresses
- RESET_ADDR, 0, first fetch address after reset

Ports:
- clk  in  1  core clock
- resetn_i  in  1  asynchronous, active-low reset
- IF_MEM_req_o  out  1  fetch request to instruction memory
- IF_MEM_addr_o  out  BITSIZE  fetch address, word aligned
- MEM_IF_valid_i  in  1  memory response valid, completes the outstanding request
- MEM_IF_data_i  in  32  instruction word, sampled when MEM_IF_valid_i=1
- IF_ID_give_o  out  1  instruction available for ID
- ID_IF_get_i  in  1  ID ready to accept
- IF_ID_instr_o  out  32  instruction to ID
- IF_ID_pc_o  out  BITSIZE  PC of IF_ID_instr_o
- EX_IF_branch_i  in  1  redirect pulse from EX
- EX_IF_target_i  in  BITSIZE  redirect target, valid with EX_IF_branch_i

## Operation
- Transfer to ID occurs in a cycle where IF_ID_give_o=1 and ID_IF_get_i=1; exactly one instruction per transfer.
- Memory protocol: IF_MEM_req_o held high with IF_MEM_addr_o stable until a cycle with MEM_IF_valid_i=1; valid may arrive in the same cycle req rises (zero wait) or any later cycle. One outstanding request max.
- Registers: pc (next fetch address), instr_buf, pc_buf, state.
- States and transitions (EX_IF_branch_i has priority in every state):
  - IDLE: entered on reset, outputs idle. Next: REQ. Branch: pc←target.
  - REQ: IF_MEM_req_o=1, IF_MEM_addr_o=pc. valid & !branch: instr_buf←data, pc_buf←pc, pc←pc+4, →GIVE. valid & branch: data dropped, pc←target, stay REQ. !valid & branch: pc←target, →DISCARD. Otherwise stay.
  - DISCARD: IF_MEM_req_o=1, address of the abandoned request held. valid: data dropped, →REQ. Branch: pc←newest target, stay DISCARD.
  - GIVE: IF_ID_give_o=!EX_IF_branch_i (combinational gate), outputs instr_buf/pc_buf. get & !branch: →REQ. Branch: buffer discarded, pc←target, →REQ (no transfer that cycle even if get=1). Otherwise hold outputs stable.
- Target low two bits forced to 0. PC increment is modulo 2^BITSIZE (all-ones-aligned +4 wraps to 0).
- IF_ID_instr_o/IF_ID_pc_o hold last buffer value outside GIVE; meaningful only with give.

## Timing
- Reset (async assert, any state): state=IDLE, pc=RESET_ADDR, IF_MEM_req_o=0, IF_MEM_addr_o=RESET_ADDR, IF_ID_give_o=0, IF_ID_instr_o=0, IF_ID_pc_o=0. Reset mid-request abandons it; memory must tolerate an abandoned request.
- First request: cycle 1 after reset release (IDLE occupies cycle 0).
- valid in cycle n → IF_ID_give_o=1 in cycle n+1.
- Transfer in cycle m → IF_MEM_req_o=1 with next address in cycle m+1.
- Peak throughput with zero-wait memory and ID always ready: one instruction per 2 cycles.
- Branch in cycle b: first request to target no earlier than b+1 (REQ/GIVE) or the cycle after the pending response (DISCARD). No instruction fetched before the redirect reaches ID after cycle b.
- ID stall (give=1, get=0): outputs stable, no new request issued.

## Test plan
- Reset release, zero-wait memory, ID always ready, RESET_ADDR=0 → requests at 0x0,0x4,0x8, each instruction delivered with matching pc, give every 2nd cycle.
- ID holds get=0 for 5 cycles during GIVE → give stays 1, instr/pc stable, req stays 0; release → one transfer, next request 0x4.
- Memory valid delayed 3 cycles → addr stable at 0x8 and req high all 3 cycles; give one cycle after valid.
- Branch to 0x103 while request to 0x8 pending → DISCARD, returned 0x8 word never given, next request addr 0x100, delivered with pc 0x100.
- Branch to 0x40 in GIVE with get=1 same cycle → no transfer, next request 0x40; pc 0xFFFFFFFC fetch → next request 0x0.
- Assert resetn_i low mid-REQ → all outputs reset values immediately; fetch restarts at RESET_ADDR.
